// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port (fetch/data) memory arbiter.
// Used by mem_arbiter and arb_pick.
package arb_pkg;

    localparam int unsigned BYTE_ADDR_W = 32;
    localparam int unsigned RESP_W      = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_e;

    // Wide zero, narrowed at the point of use to the response data width.
    localparam logic [RESP_W-1:0] RESP_ZERO = '0;

    function automatic logic word_aligned(input logic [BYTE_ADDR_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way picker between the fetch and data requesters.
// RR_EN=1 favours the port not granted last on a conflict; otherwise data wins.
module arb_pick
    import arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic      fetch_req_i,
    input  logic      data_req_i,
    input  arb_port_e last_grant_i,
    output logic      any_req_c_o,
    output arb_port_e grant_c_o
);

    always_comb begin
        any_req_c_o = fetch_req_i | data_req_i;
        grant_c_o   = data_req_i ? PORT_D : PORT_I;
        if (RR_EN && fetch_req_i && data_req_i) begin
            grant_c_o = (last_grant_i == PORT_D) ? PORT_I : PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-cycle memory between a read-only fetch
// port and a read/write data port. Define ARB_ROUND_ROBIN_EN for round-robin.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic              i_err,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(RESP_ZERO);

    // Assert asynchronously, release on the clock.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    arb_state_e        state_q,     state_d;
    arb_port_e         grant_q,     grant_d;
    logic              acc_err_q,   acc_err_d;
    logic              acc_wr_q,    acc_wr_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ack_q,     i_ack_d;
    logic              i_err_q,     i_err_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic              d_ack_q,     d_ack_d;
    logic              d_err_q,     d_err_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

    logic              any_req_c;
    arb_port_e         pick_c;
    arb_port_e         last_grant_c;
    logic [31:0]       sel_addr_c;
    logic              sel_aligned_c;
    logic [DATA_W-1:0] acc_rdata_c;
    logic              unused_addr_c;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;

    arb_port_e last_grant_q, last_grant_d;
    logic      grant_en_c;

    assign grant_en_c   = (state_q != ST_ACCESS) && any_req_c;
    assign last_grant_d = grant_en_c ? pick_c : last_grant_q;
    assign last_grant_c = last_grant_q;

    // Pointer starts at fetch so data wins the first conflict.
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            last_grant_q <= PORT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    localparam bit RR_EN = 1'b0;

    assign last_grant_c = PORT_I;
`endif

    arb_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .fetch_req_i  (i_req),
        .data_req_i   (d_req),
        .last_grant_i (last_grant_c),
        .any_req_c_o  (any_req_c),
        .grant_c_o    (pick_c)
    );

    assign sel_addr_c    = (pick_c == PORT_D) ? d_addr : i_addr;
    assign sel_aligned_c = word_aligned(sel_addr_c);
    // Upper byte-address bits wrap within the memory.
    assign unused_addr_c = ^sel_addr_c[31:ADDR_W+2];
    assign acc_rdata_c   = (acc_err_q || acc_wr_q) ? DATA_ZERO : mem_rdata;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        acc_err_d   = acc_err_q;
        acc_wr_d    = acc_wr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        i_rdata_d   = DATA_ZERO;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = DATA_ZERO;

        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (any_req_c) begin
                    state_d     = ST_ACCESS;
                    grant_d     = pick_c;
                    acc_err_d   = !sel_aligned_c;
                    acc_wr_d    = (pick_c == PORT_D) && d_we;
                    mem_addr_d  = sel_addr_c[ADDR_W+1:2];
                    mem_wdata_d = d_wdata;
                    mem_we_d    = (pick_c == PORT_D) && d_we && sel_aligned_c;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (grant_q == PORT_D) begin
                    d_ack_d   = 1'b1;
                    d_err_d   = acc_err_q;
                    d_rdata_d = acc_rdata_c;
                end else begin
                    i_ack_d   = 1'b1;
                    i_err_d   = acc_err_q;
                    i_rdata_d = acc_rdata_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q     <= ST_IDLE;
            grant_q     <= PORT_I;
            acc_err_q   <= 1'b0;
            acc_wr_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= DATA_ZERO;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= DATA_ZERO;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= DATA_ZERO;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            acc_err_q   <= acc_err_d;
            acc_wr_q    <= acc_wr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            i_rdata_q   <= i_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed latency/reset/contention cases
// followed by random traffic checked against a word-array reference model.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam bit          P_I    = 1'b0;
    localparam bit          P_D    = 1'b1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_ack;
    logic              i_err;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT, and the bench's own expectation of its contents.
    logic [DATA_W-1:0] ram     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] = mem_wdata;
    end
    assign mem_rdata = ram[mem_addr];

    typedef struct packed {
        logic              port;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

`ifdef ARB_ROUND_ROBIN_EN
    bit tb_last = P_I;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Who the arbitration rules say wins when both ports ask together.
    function automatic bit conflict_winner();
`ifdef ARB_ROUND_ROBIN_EN
        return (tb_last == P_I) ? P_D : P_I;
`else
        return P_D;
`endif
    endfunction

    // Reference behaviour of one granted access, applied in service order.
    function automatic void expect_op(input bit port, input logic [31:0] a,
                                      input logic we, input logic [DATA_W-1:0] wd);
        exp_t              e;
        logic [ADDR_W-1:0] idx;
        idx    = a[ADDR_W+1:2];
        e.port = port;
        if (a[1:0] != 2'b00) begin
            e.err   = 1'b1;
            e.rdata = '0;
        end else if (port == P_D && we) begin
            ref_mem[idx] = wd;
            e.err        = 1'b0;
            e.rdata      = '0;
        end else begin
            e.err   = 1'b0;
            e.rdata = ref_mem[idx];
        end
        exp_q.push_back(e);
`ifdef ARB_ROUND_ROBIN_EN
        tb_last = port;
`endif
    endfunction

    always @(negedge clk) begin
        chk("i_err_without_ack", 64'(i_err & ~i_ack), 64'(0));
        chk("d_err_without_ack", 64'(d_err & ~d_ack), 64'(0));
        if (i_ack && d_ack) begin
            checks++;
            failures++;
            $display("FAIL two_acks actual=both expected=one t=%0t", $time);
        end else if (i_ack || d_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=ack expected=none t=%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_port", 64'(d_ack), 64'(mon_e.port));
                chk("ack_err", 64'(d_ack ? d_err : i_err), 64'(mon_e.err));
                chk("ack_rdata", 64'(d_ack ? d_rdata : i_rdata), 64'(mon_e.rdata));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        tb_last = P_I;
`endif
        repeat (3) tick();
    endtask

    // Single request with cycle-exact checks: access in N+1, one-cycle ack in N+2.
    task automatic single_op(input string tag, input bit port, input logic [31:0] a,
                             input logic we, input logic [DATA_W-1:0] wd);
        logic exp_we;
        exp_we = (port == P_D) && we && (a[1:0] == 2'b00);
        expect_op(port, a, we, wd);
        if (port == P_D) begin
            d_req = 1'b1; d_addr = a; d_we = we; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = a;
        end
        tick();
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(exp_we));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(a[ADDR_W+1:2]));
        chk({tag, "_early_ack"}, 64'({i_ack, d_ack}), 64'(0));
        tick();
        chk({tag, "_ack"}, 64'((port == P_D) ? {i_ack, d_ack} : {d_ack, i_ack}), 64'(1));
        chk({tag, "_mem_we_resp"}, 64'(mem_we), 64'(0));
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();
        chk({tag, "_ack_one_cycle"}, 64'({i_ack, d_ack}), 64'(0));
    endtask

    // Requesters hold until acked; both-request order follows the arbitration rules.
    task automatic run_txn(input bit ui, input bit ud, input logic [31:0] ia,
                           input logic [31:0] da, input logic dwe, input logic [DATA_W-1:0] dwd);
        if (ui && ud) begin
            if (conflict_winner() == P_D) begin
                expect_op(P_D, da, dwe, dwd);
                expect_op(P_I, ia, 1'b0, '0);
            end else begin
                expect_op(P_I, ia, 1'b0, '0);
                expect_op(P_D, da, dwe, dwd);
            end
        end else if (ud) begin
            expect_op(P_D, da, dwe, dwd);
        end else if (ui) begin
            expect_op(P_I, ia, 1'b0, '0);
        end
        i_req = ui; i_addr = ia;
        d_req = ud; d_addr = da; d_we = dwe; d_wdata = dwd;
        for (int c = 0; c < 40 && (i_req || d_req); c++) begin
            tick();
            if (d_ack) begin d_req = 1'b0; d_we = 1'b0; end
            if (i_ack) i_req = 1'b0;
        end
        if (i_req || d_req) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout actual=no_ack expected=ack t=%0t", $time);
            i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 7));
        a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return a;
    endfunction

    initial begin
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] old;
        int                n_i;
        int                n_d;

        for (int k = 0; k < int'(DEPTH); k++) begin
            v          = $urandom;
            ram[k]     = v;
            ref_mem[k] = v;
        end
        rst_n = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_acks", 64'({i_ack, d_ack}), 64'(0));
        chk("rst_errs", 64'({i_err, d_err}), 64'(0));
        chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
        do_reset();

        // Contention from a fresh reset: both held high for 8 cycles.
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_addr = 32'h24; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (conflict_winner() == P_D) expect_op(P_D, 32'h24, 1'b0, '0);
            else                          expect_op(P_I, 32'h20, 1'b0, '0);
        end
        n_i = 0; n_d = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_i += int'(i_ack);
            n_d += int'(d_ack);
        end
        i_req = 1'b0; d_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        chk("contend_d_acks", 64'(n_d), 64'(2));
        chk("contend_i_acks", 64'(n_i), 64'(2));
`else
        chk("contend_d_acks", 64'(n_d), 64'(4));
        chk("contend_i_acks", 64'(n_i), 64'(0));
`endif
        repeat (2) tick();
        chk("contend_quiet", 64'({i_ack, d_ack}), 64'(0));

        single_op("wr10", P_D, 32'h10, 1'b1, 32'hDEADBEEF);
        chk("wr10_ram", 64'(ram[4]), 64'(32'hDEADBEEF));
        single_op("rd10", P_D, 32'h10, 1'b0, '0);
        single_op("misal13", P_D, 32'h13, 1'b1, 32'hCAFEF00D);
        chk("misal13_ram", 64'(ram[4]), 64'(32'hDEADBEEF));
        single_op("ird", P_I, 32'h0000_1014, 1'b0, '0);

        // Continuous fetch: ack every second cycle, upper address bits wrap.
        i_req = 1'b1; i_addr = 32'h1004;
        for (int k = 0; k < 3; k++) expect_op(P_I, 32'h1004, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ifetch_gap", 64'(i_ack), 64'(0));
            chk("ifetch_addr", 64'(mem_addr), 64'(1));
            tick();
            chk("ifetch_ack", 64'(i_ack), 64'(1));
        end
        i_req = 1'b0;
        tick();
        chk("ifetch_stop", 64'(i_ack), 64'(0));

        // Reset while a write is in its access cycle.
        old = ref_mem[16];
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = ~old;
        tick();
        chk("abort_mem_we_before", 64'(mem_we), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_we_now", 64'(mem_we), 64'(0));
        chk("abort_no_ack", 64'(d_ack), 64'(0));
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("abort_ram_kept", 64'(ram[16]), 64'(old));
        rst_n = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        tb_last = P_I;
`endif
        repeat (4) tick();
        single_op("after_abort", P_D, 32'h40, 1'b0, '0);

        for (int t = 0; t < 60; t++) begin
            logic ui;
            logic ud;
            ui = 1'($urandom_range(0, 1));
            ud = 1'($urandom_range(0, 1));
            if (!ui && !ud) ud = 1'b1;
            run_txn(ui, ud, rnd_addr(), rnd_addr(), 1'($urandom_range(0, 1)), DATA_W'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (5) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
